// File: rtl/inst_sram_resp_pkg.sv
// Shared constants for the instruction SRAM responder: output reset values,
// default window base and the window/alignment check helper.
// Optional feature macro used by the top: INST_SRAM_PERF_CNT_EN.
package inst_sram_resp_pkg;

  // Reset (initial) values of the registered outputs
  localparam logic [31:0] INI_SRAM_RDATA    = 32'h0000_0000;
  localparam logic        INI_SRAM_ADDR_ERR = 1'b0;

  // Default physical byte address of word 0 (MIPS boot vector)
  localparam logic [31:0] SRAM_BASE_ADDR_DEF = 32'h1fc0_0000;

  // Window check constants: low address bits of an aligned word access,
  // and log2 of the bytes per word
  localparam logic [1:0]  SRAM_ALIGN_OK    = 2'b00;
  localparam int unsigned SRAM_WORD_SHIFT  = 2;

  // True when the byte offset lies inside a 2^addr_w word window and the
  // access is word aligned. The limit is computed in 33 bits so a window
  // that covers the whole 32-bit space does not overflow.
  function automatic logic sram_in_window(input logic [31:0] offset,
                                          input logic [1:0]  addr_lo,
                                          input int unsigned addr_w);
    logic [32:0] limit;
    limit = 33'd1 << (addr_w + SRAM_WORD_SHIFT);
    return ({1'b0, offset} < limit) && (addr_lo == SRAM_ALIGN_OK);
  endfunction

endpackage

// File: rtl/sram_byte_lane.sv
// One 8-bit byte lane of the instruction SRAM: 2^ADDR_W deep, read-first,
// registered read, single write enable. No reset: contents persist and the
// top masks the read register when its value must not be shown.
module sram_byte_lane #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              i_re,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [7:0]        i_wdata,
  output logic [7:0]        o_rdata
);

  logic [7:0] r_mem [2**ADDR_W];
  logic [7:0] r_rdata;

  // Read-first port: the read register captures the word before the write lands
  always_ff @(posedge clk) begin
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/inst_sram_resp.sv
// Instruction SRAM responder: single-cycle-latency word memory mapped at
// BASE_ADDR, byte-lane writes, error flag for out-of-window or misaligned
// accesses. Defining INST_SRAM_PERF_CNT_EN adds read/write access counters.
module inst_sram_resp
  import inst_sram_resp_pkg::*;
#(
  parameter int          ADDR_W    = 14,
  parameter logic [31:0] BASE_ADDR = SRAM_BASE_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sram_en,
  input  logic [3:0]  sram_wen,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic        sram_addr_err
`ifdef INST_SRAM_PERF_CNT_EN
  ,
  output logic [31:0] perf_rd_cnt,
  output logic [31:0] perf_wr_cnt
`endif
);

  logic              w_accept;
  logic [31:0]       w_offset;
  logic              w_in_win;
  logic              w_lane_re;
  logic [ADDR_W-1:0] w_word;
  logic [31:0]       w_lane_rdata;
  logic              r_zero;
  logic              r_addr_err;

  assign w_accept  = rst_n & sram_en;
  assign w_offset  = sram_addr - BASE_ADDR;
  assign w_in_win  = sram_in_window(w_offset, sram_addr[1:0], ADDR_W);
  assign w_word    = w_offset[ADDR_W+1:2];
  assign w_lane_re = w_accept & w_in_win;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      sram_byte_lane #(
        .ADDR_W (ADDR_W)
      ) u_lane (
        .clk     (clk),
        .i_re    (w_lane_re),
        .i_we    (w_lane_re & sram_wen[gi]),
        .i_addr  (w_word),
        .i_wdata (sram_wdata[8*gi +: 8]),
        .o_rdata (w_lane_rdata[8*gi +: 8])
      );
    end
  endgenerate

  // Response status: r_zero forces rdata to its reset value after reset and
  // after a rejected access; both flags hold while sram_en is low
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_zero     <= 1'b1;
      r_addr_err <= INI_SRAM_ADDR_ERR;
    end else if (sram_en) begin
      r_zero     <= ~w_in_win;
      r_addr_err <= ~w_in_win;
    end
  end

  assign sram_rdata    = r_zero ? INI_SRAM_RDATA : w_lane_rdata;
  assign sram_addr_err = r_addr_err;

`ifdef INST_SRAM_PERF_CNT_EN
  logic [31:0] r_perf_rd_cnt;
  logic [31:0] r_perf_wr_cnt;

  // Count every accepted access, in window or not; wraps naturally at 2^32
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_rd_cnt <= 32'd0;
      r_perf_wr_cnt <= 32'd0;
    end else if (sram_en) begin
      if (sram_wen == 4'b0000) begin
        r_perf_rd_cnt <= r_perf_rd_cnt + 32'd1;
      end else begin
        r_perf_wr_cnt <= r_perf_wr_cnt + 32'd1;
      end
    end
  end

  assign perf_rd_cnt = r_perf_rd_cnt;
  assign perf_wr_cnt = r_perf_wr_cnt;
`endif

endmodule

// File: doc/inst_sram_resp.md
INST_SRAM_RESP -- requirements
Module: inst_sram_resp

Interface
REQ-001 SHALL provide parameter ADDR_W, default 14, meaning word-index width (memory depth = 2^ADDR_W words of 32 bits).
REQ-002 SHALL provide parameter BASE_ADDR, default 32'h1fc0_0000, meaning the physical byte address of word 0.
REQ-003 SHALL provide port clk, input, 1 bit, the single system clock; all state changes on its rising edge.
REQ-004 SHALL provide port rst_n, input, 1 bit, synchronous active-low reset.
REQ-005 SHALL provide port sram_en, input, 1 bit, access enable.
REQ-006 SHALL provide port sram_wen, input, 4 bits, byte-lane write enables; bit i covers wdata[8i+7:8i].
REQ-007 SHALL provide port sram_addr, input, 32 bits, physical byte address.
REQ-008 SHALL provide port sram_wdata, input, 32 bits, write data.
REQ-009 SHALL provide port sram_rdata, output, 32 bits, read data.
REQ-010 SHALL provide port sram_addr_err, output, 1 bit, flags that the last accepted access was out of window or misaligned.

Function
REQ-011 SHALL accept an access on every rising edge where rst_n=1 and sram_en=1; there is no stall and no ready signal.
REQ-012 SHALL compute the window offset as sram_addr minus BASE_ADDR (32-bit wrap-around arithmetic) and the word index as offset[ADDR_W+1:2].
REQ-013 SHALL treat an access as in-window only when offset < 4*2^ADDR_W and sram_addr[1:0]=2'b00.
REQ-014 SHALL present the addressed word on sram_rdata exactly one cycle after the accepting edge.
REQ-015 SHALL be read-first: when a read and a write hit the same word in the same cycle, sram_rdata returns the pre-write contents.
REQ-016 SHALL write only the lanes whose sram_wen bit is set, and only for in-window accepted accesses.
REQ-017 SHALL also update sram_rdata on a write access, with the old word per REQ-015.
REQ-018 SHALL hold sram_rdata and sram_addr_err unchanged in any cycle where sram_en=0.
REQ-019 SHALL, for an out-of-window or misaligned accepted access, suppress the write, drive sram_rdata to 32'h0 and set sram_addr_err to 1 in the following cycle.
REQ-020 SHALL clear sram_addr_err on the next accepted in-window access.
REQ-021 SHALL accept back-to-back accesses on consecutive cycles with independent addresses at full throughput.

Reset
REQ-022 SHALL, while rst_n=0, drive sram_rdata to 32'h0 and sram_addr_err to 0 from the next edge onward, ignore sram_en, and block all writes.
REQ-023 SHALL retain memory contents across reset; the array itself is not cleared.
REQ-024 SHALL, when reset is asserted mid-stream, discard the pending read result, so the first edge after rst_n rises behaves as a fresh access.

Configuration
REQ-025 SHALL, when the macro INST_SRAM_PERF_CNT_EN is defined, add 32-bit outputs perf_rd_cnt and perf_wr_cnt that count accepted reads (sram_wen=0) and accepted writes (sram_wen!=0) respectively, including out-of-window accesses.
REQ-026 SHALL reset both counters to 0, wrap them at 2^32, and freeze them while rst_n=0.
REQ-027 SHALL, without INST_SRAM_PERF_CNT_EN, omit both ports and both counters entirely, leaving behaviour otherwise identical.

Structure
REQ-028 SHALL place the reset values of sram_rdata, the default BASE_ADDR value and the window-check constants in the shared defines header, alongside the existing ini_ constants.
REQ-029 SHALL implement storage as four instances of one sub-module, sram_byte_lane (8-bit wide, 2^ADDR_W deep, read-first, single write enable), one per byte lane.

Verification
REQ-030 SHALL be verified by: after reset, read 32'h1fc0_0000 -> sram_rdata=preloaded word 0 one cycle later, sram_addr_err=0.
REQ-031 SHALL be verified by: write 32'hAABBCCDD with wen=4'b0101 at 32'h1fc0_0004 over old word 32'h11223344, then read it -> 32'h11BB33DD.
REQ-032 SHALL be verified by: same-cycle write 32'hDEADBEEF (wen=4'hF) to 32'h1fc0_0008 holding 32'h0 -> sram_rdata=32'h0 the next cycle; a read the cycle after -> 32'hDEADBEEF.
REQ-033 SHALL be verified by: read 32'h1fc0_0002, then write 32'hFFFF_FFFF to 32'h0000_0000 -> sram_rdata=0 with sram_addr_err=1 after each access, memory unchanged, and the next in-window read clears sram_addr_err.
REQ-034 SHALL be verified by: a read of word 5 followed by two cycles of sram_en=0 -> sram_rdata holds word 5; then rst_n=0 for one cycle -> sram_rdata=0 while previously written data is still readable afterwards.
REQ-035 SHALL be verified, with INST_SRAM_PERF_CNT_EN defined, by: 3 reads and 2 writes including one out-of-window -> perf_rd_cnt=3 and perf_wr_cnt=2.
